load_return_stage: RTL and testbench

- Memory-stage load return path between the data memories and the writeback mux.
- Captures load attributes at issue (X stage), selects the returning word from BIOS, DMEM or MMIO one cycle later, then aligns and sign/zero-extends it into the load value consumed by writeback.
- Holds the extended value across pipeline stalls, since the synchronous memories' outputs are not stable while the pipeline is frozen.

---
 rtl/load_return_stage.sv | 152 +++++++++++++++
 tb/tb_load_return_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_return_stage.sv
// Memory-stage load return: selects BIOS/DMEM/MMIO read data one cycle after issue,
// aligns and extends it, and holds it across stalls. LOAD_MISALIGN_CHECK_EN adds misalignment flagging.
module load_return_stage #(
   parameter logic [3:0] BIOS_REGION = 4'b0100,
   parameter logic [3:0] IO_REGION   = 4'b1000,
   parameter logic [3:0] DMEM_MASK   = 4'b1101
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_funct3,
   input  logic        stall,
   input  logic [31:0] bios_dout,
   input  logic [31:0] dmem_dout,
   input  logic [31:0] io_dout,
   output logic [31:0] dmem_lex,
   output logic        lex_valid,
   output logic        misaligned
);
   // state | meaning
   // IDLE  | no load completing this cycle
   // RESP  | memory dout valid, extended value driven straight through
   // HOLD  | pipeline frozen, value driven from hold registers
   typedef enum logic [1:0] {S_IDLE, S_RESP, S_HOLD} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_BIOS, SRC_DMEM, SRC_IO} src_t;

   state_t      state_q, state_d;
   src_t        src_q, src_d, src_in;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] hold_data_q, hold_data_d;
   logic        hold_mis_q, hold_mis_d;

   logic        issue;
   logic [31:0] word_sel, ext_val, resp_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        resp_mis;
   logic        unused_addr;

   assign issue       = ld_valid & ~stall;
   assign unused_addr = ^ld_addr[27:2];

   always_comb begin
      src_in = SRC_NONE;
      if (ld_addr[31:28] == BIOS_REGION)
         src_in = SRC_BIOS;
      else if (ld_addr[31:28] == IO_REGION)
         src_in = SRC_IO;
      else if ((ld_addr[31:28] & DMEM_MASK) == 4'b0001)
         src_in = SRC_DMEM;
   end

   always_comb begin
      word_sel = 32'h0;
      case (src_q)
         SRC_BIOS: word_sel = bios_dout;
         SRC_DMEM: word_sel = dmem_dout;
         SRC_IO:   word_sel = io_dout;
         default:  word_sel = 32'h0;
      endcase
      byte_sel = word_sel[7:0];
      case (off_q)
         2'd1:    byte_sel = word_sel[15:8];
         2'd2:    byte_sel = word_sel[23:16];
         2'd3:    byte_sel = word_sel[31:24];
         default: byte_sel = word_sel[7:0];
      endcase
      half_sel = off_q[1] ? word_sel[31:16] : word_sel[15:0];
      case (f3_q)
         3'b000:  ext_val = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ext_val = {24'h0, byte_sel};
         3'b001:  ext_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  ext_val = {16'h0, half_sel};
         default: ext_val = word_sel;
      endcase
   end

`ifdef LOAD_MISALIGN_CHECK_EN
   always_comb begin
      case (f3_q)
         3'b000, 3'b100: resp_mis = 1'b0;
         3'b001, 3'b101: resp_mis = off_q[0];
         default:        resp_mis = |off_q;
      endcase
      resp_data = resp_mis ? 32'h0 : ext_val;
   end
`else
   assign resp_mis  = 1'b0;
   assign resp_data = ext_val;
`endif

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      off_d       = off_q;
      f3_d        = f3_q;
      hold_data_d = hold_data_q;
      hold_mis_d  = hold_mis_q;
      dmem_lex    = 32'h0;
      lex_valid   = 1'b0;
      misaligned  = 1'b0;
      if (issue) begin
         src_d = src_in;
         off_d = ld_addr[1:0];
         f3_d  = ld_funct3;
      end
      case (state_q)
         S_IDLE: begin
            if (issue) state_d = S_RESP;
         end
         S_RESP: begin
            dmem_lex   = resp_data;
            lex_valid  = 1'b1;
            misaligned = resp_mis;
            if (stall) begin
               hold_data_d = resp_data;
               hold_mis_d  = resp_mis;
               state_d     = S_HOLD;
            end else begin
               state_d = issue ? S_RESP : S_IDLE;
            end
         end
         S_HOLD: begin
            dmem_lex   = hold_data_q;
            lex_valid  = 1'b1;
            misaligned = hold_mis_q;
            if (!stall) state_d = issue ? S_RESP : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         src_q       <= SRC_NONE;
         off_q       <= 2'd0;
         f3_q        <= 3'd0;
         hold_data_q <= 32'h0;
         hold_mis_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         hold_data_q <= hold_data_d;
         hold_mis_q  <= hold_mis_d;
      end
   end
endmodule

// File: tb/tb_load_return_stage.sv
// Self-checking bench for load_return_stage: directed scenarios then random traffic
// against a cycle-level reference model of the load return rules.
module tb_load_return_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [2:0]  ld_funct3;
   logic        stall;
   logic [31:0] bios_dout, dmem_dout, io_dout;
   logic [31:0] dmem_lex;
   logic        lex_valid, misaligned;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: pending load from last cycle, or a held value
   bit          m_pend, m_held, m_hmis;
   logic [31:0] m_addr, m_hval;
   logic [2:0]  m_f3;
   logic [31:0] e_data;
   bit          e_valid, e_mis;

   load_return_stage dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
      .stall(stall), .bios_dout(bios_dout), .dmem_dout(dmem_dout), .io_dout(io_dout),
      .dmem_lex(dmem_lex), .lex_valid(lex_valid), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pick_word(input logic [31:0] a);
      int nib;
      nib = int'(a[31:28]);
      if (nib == 4) return bios_dout;
      if (nib == 8) return io_dout;
      if (nib == 1 || nib == 3) return dmem_dout;
      return 32'h0;
   endfunction

   task automatic model_expect();
      logic [31:0] w;
      longint unsigned v;
      int off;
      bit is_b, is_h;
      e_valid = 1'b0; e_data = 32'h0; e_mis = 1'b0;
      if (m_held) begin
         e_valid = 1'b1; e_data = m_hval; e_mis = m_hmis;
      end else if (m_pend) begin
         e_valid = 1'b1;
         w   = pick_word(m_addr);
         off = int'(m_addr[1:0]);
         is_b = (m_f3 == 3'd0) || (m_f3 == 3'd4);
         is_h = (m_f3 == 3'd1) || (m_f3 == 3'd5);
         if (is_b) begin
            v = (longint'(w) / (longint'(1) << (8 * off))) % 256;
            if (m_f3 == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
         end else if (is_h) begin
            v = (longint'(w) / (off >= 2 ? 65536 : 1)) % 65536;
            if (m_f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
         end else begin
            v = longint'(w);
         end
         e_data = v[31:0];
`ifdef LOAD_MISALIGN_CHECK_EN
         e_mis = is_h ? (off % 2 == 1) : (!is_b && off != 0);
         if (e_mis) e_data = 32'h0;
`endif
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] a, input logic [2:0] f, input bit s,
                        input logic [31:0] b, input logic [31:0] d, input logic [31:0] i);
      ld_valid = v; ld_addr = a; ld_funct3 = f; stall = s;
      bios_dout = b; dmem_dout = d; io_dout = i;
      #1;
      model_expect();
      chk("lex_valid", {31'h0, lex_valid}, {31'h0, e_valid});
      chk("dmem_lex", dmem_lex, e_data);
      chk("misaligned", {31'h0, misaligned}, {31'h0, e_mis});
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_pend = 0; m_held = 0;
      end else begin
         if (e_valid && stall) begin
            m_held = 1; m_hval = e_data; m_hmis = e_mis;
         end else begin
            m_held = 0;
         end
         m_pend = ld_valid && !stall;
         if (m_pend) begin m_addr = ld_addr; m_f3 = ld_funct3; end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         drive(0, 32'h0, 3'd0, 0, 32'h0, 32'h0, 32'h0);
         tick();
      end
   endtask

   initial begin
      logic [31:0] a;
      int sel;
      m_pend = 0; m_held = 0; m_hmis = 0; m_addr = 0; m_hval = 0; m_f3 = 0;
      rst = 1'b1;
      ld_valid = 0; ld_addr = 0; ld_funct3 = 0; stall = 0;
      bios_dout = 32'hFFFF_FFFF; dmem_dout = 32'hFFFF_FFFF; io_dout = 32'hFFFF_FFFF;
      #2;
      chk("rst_lex", dmem_lex, 32'h0);
      chk("rst_valid", {31'h0, lex_valid}, 32'h0);
      chk("rst_mis", {31'h0, misaligned}, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      idle(2);

      // LB signed
      drive(1, 32'h1000_0003, 3'b000, 0, 32'h0, 32'h0, 32'h0); tick();
      drive(0, 32'h0, 3'd0, 0, 32'h0, 32'h80FF_1234, 32'h0);
      chk("lb_val", dmem_lex, 32'hFFFF_FF80);
      chk("lb_valid", {31'h0, lex_valid}, 32'h1);
      tick();
      drive(0, 32'h0, 3'd0, 0, 32'h0, 32'h80FF_1234, 32'h0);
      chk("lb_done", {31'h0, lex_valid}, 32'h0);
      tick();

      // halves from BIOS
      drive(1, 32'h4000_0002, 3'b101, 0, 32'h0, 32'h0, 32'h0); tick();
      drive(1, 32'h4000_0002, 3'b001, 0, 32'hBEEF_0001, 32'h0, 32'h0);
      chk("lhu_bios", dmem_lex, 32'h0000_BEEF);
      tick();
      drive(0, 32'h0, 3'd0, 0, 32'hBEEF_0001, 32'h0, 32'h0);
      chk("lh_bios", dmem_lex, 32'hFFFF_BEEF);
      tick();

      // stall hold
      drive(1, 32'h8000_0000, 3'b010, 0, 32'h0, 32'h0, 32'h0); tick();
      drive(0, 32'h0, 3'd0, 1, 32'h0, 32'h0, 32'hCAFE_F00D);
      chk("hold0", dmem_lex, 32'hCAFE_F00D); tick();
      drive(0, 32'h0, 3'd0, 1, 32'h0, 32'h0, 32'h0);
      chk("hold1", dmem_lex, 32'hCAFE_F00D); tick();
      drive(0, 32'h0, 3'd0, 1, 32'h0, 32'h0, 32'h0);
      chk("hold2", dmem_lex, 32'hCAFE_F00D); tick();
      drive(0, 32'h0, 3'd0, 0, 32'h0, 32'h0, 32'h0);
      chk("hold_rel", dmem_lex, 32'hCAFE_F00D);
      chk("hold_rel_v", {31'h0, lex_valid}, 32'h1); tick();
      drive(0, 32'h0, 3'd0, 0, 32'h0, 32'h0, 32'h0);
      chk("hold_end_v", {31'h0, lex_valid}, 32'h0); tick();

      // back-to-back
      drive(1, 32'h1000_0000, 3'b010, 0, 32'h0, 32'h0, 32'h0); tick();
      drive(1, 32'h1000_0001, 3'b100, 0, 32'h0, 32'h1111_1111, 32'h0);
      chk("b2b_0", dmem_lex, 32'h1111_1111); tick();
      drive(0, 32'h0, 3'd0, 0, 32'h0, 32'h0000_AB00, 32'h0);
      chk("b2b_1", dmem_lex, 32'h0000_00AB);
      chk("b2b_1v", {31'h0, lex_valid}, 32'h1); tick();

      // misaligned word
      drive(1, 32'h1000_0002, 3'b010, 0, 32'h0, 32'h0, 32'h0); tick();
      drive(0, 32'h0, 3'd0, 0, 32'h0, 32'h1234_5678, 32'h0);
`ifdef LOAD_MISALIGN_CHECK_EN
      chk("mis_lw", dmem_lex, 32'h0);
      chk("mis_flag", {31'h0, misaligned}, 32'h1);
`else
      chk("mis_lw", dmem_lex, 32'h1234_5678);
      chk("mis_flag", {31'h0, misaligned}, 32'h0);
`endif
      tick();

      // unmapped region
      drive(1, 32'h2000_0000, 3'b010, 0, 32'h0, 32'h0, 32'h0); tick();
      drive(0, 32'h0, 3'd0, 0, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC);
      chk("none_val", dmem_lex, 32'h0);
      chk("none_v", {31'h0, lex_valid}, 32'h1); tick();

      // reset during HOLD
      drive(1, 32'h1000_0000, 3'b010, 0, 32'h0, 32'h0, 32'h0); tick();
      drive(0, 32'h0, 3'd0, 1, 32'h0, 32'h5555_AAAA, 32'h0); tick();
      drive(0, 32'h0, 3'd0, 1, 32'h0, 32'h0, 32'h0);
      chk("pre_rst", dmem_lex, 32'h5555_AAAA);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_lex", dmem_lex, 32'h0);
      chk("rst_async_v", {31'h0, lex_valid}, 32'h0);
      tick();
      rst = 1'b0;
      drive(0, 32'h0, 3'd0, 1, 32'h0, 32'h0, 32'h0); tick();
      drive(0, 32'h0, 3'd0, 0, 32'h0, 32'h0, 32'h0);
      chk("post_rst_v", {31'h0, lex_valid}, 32'h0); tick();
      idle(2);

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         sel = int'($urandom_range(0, 5));
         a = $urandom;
         case (sel)
            0: a[31:28] = 4'h1;
            1: a[31:28] = 4'h3;
            2: a[31:28] = 4'h4;
            3: a[31:28] = 4'h8;
            4: a[31:28] = 4'h2;
            default: ;
         endcase
         drive($urandom_range(0, 3) != 0, a, 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
               $urandom, $urandom, $urandom);
         tick();
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
